// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin arbiter sharing the async FIFO read port among
// NREQ consumers in the rclk domain. A grant lasts up to BURST_MAX pops and
// is followed by at least one IDLE arbitration cycle. Read data returns one
// cycle after each pop, tagged with the owning consumer index.
// Optional build macro FIFO_RD_ARB_PRIO_EN: consumer 0 wins every
// arbitration it requests; round-robin applies only among the others.
module fifo_rd_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_rdata,
  output logic                    r_en,
  output logic [NREQ-1:0]         gnt,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [$clog2(NREQ)-1:0] rid,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [IW-1:0]   last;        // last round-robin winner
  logic [IW-1:0]   own;         // currently granted consumer
  logic [CW-1:0]   count;       // pops issued in the current grant
  logic            empty_seen;  // fifo_empty was high in the previous XFER cycle
  logic [IW-1:0]   winner;
  logic [IW-1:0]   idx;
  logic            found;
  logic            pop_last;
  logic            release_now;

  // Pick the first requester after last, wrapping modulo NREQ
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef FIFO_RD_ARB_PRIO_EN
    if (req[0]) winner = '0;
`endif
  end

  // Pop strobe: only the granted consumer, only when the FIFO has data
  assign r_en = (state == XFER) && gnt[own] && req[own] && !fifo_empty;

  // Release conditions for the current grant
  always_comb begin
    pop_last    = r_en && (count == CW'(BURST_MAX - 1));
    release_now = pop_last || !req[own] || (fifo_empty && empty_seen);
  end

  // Grant FSM: arbitrate in IDLE, stream pops in XFER until a release condition
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      last       <= IW'(NREQ - 1);
      own        <= '0;
      count      <= '0;
      empty_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req) && !fifo_empty) begin
            state      <= XFER;
            gnt        <= NREQ'(1) << winner;
            busy       <= 1'b1;
            own        <= winner;
            count      <= '0;
            empty_seen <= 1'b0;
`ifdef FIFO_RD_ARB_PRIO_EN
            if (winner != '0) last <= winner;
`else
            last       <= winner;
`endif
          end
        end
        XFER: begin
          empty_seen <= fifo_empty;
          if (r_en && (count != CW'(BURST_MAX))) count <= count + CW'(1);
          if (release_now) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read return path: data and owner tag one cycle after each pop
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= r_en;
      if (r_en) begin
        rid   <= own;
        rdata <= fifo_rdata;
      end
    end
  end

endmodule
